// File: rtl/aes_encipher_last_block_if.sv
// rtl/aes_encipher_last_block_if.sv - block/key/S-box/ciphertext bundle for the last AES encipher round
interface aes_encipher_last_block_if;
  localparam int BLK_W = 128;

  // upstream side: state from the previous round plus the last-round key
  logic [BLK_W-1:0] round_key;
  logic             in_valid;
  logic [BLK_W-1:0] in_block;
  logic             in_ready;

  // shared external S-box array
  logic [BLK_W-1:0] old_sbox;
  logic [BLK_W-1:0] new_sbox;

  // downstream side: finished ciphertext
  logic             out_valid;
  logic [BLK_W-1:0] out_block;
  logic             out_ready;

  logic             busy;

  // the round stage itself
  modport slave (
    input  round_key,
    input  in_valid,
    input  in_block,
    output in_ready,
    output old_sbox,
    input  new_sbox,
    output out_valid,
    output out_block,
    input  out_ready,
    output busy
  );

  // the surroundings: previous round, S-box array and ciphertext consumer
  modport master (
    output round_key,
    output in_valid,
    output in_block,
    input  in_ready,
    input  old_sbox,
    output new_sbox,
    input  out_valid,
    input  out_block,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/aes_encipher_last_block.sv
// rtl/aes_encipher_last_block.sv - final AES encipher round (SubBytes, ShiftRows, AddRoundKey) as a 3-stage pipe
module aes_encipher_last_block (
  input  logic                       clk,
  input  logic                       reset,
  aes_encipher_last_block_if.slave   bus
);
  localparam int NS    = 3;
  localparam int BLK_W = 128;

  // Stage indices: 0 holds the substituted bytes, 1 the row-shifted state,
  // 2 the finished ciphertext.
  localparam int ST_SUB   = 0;
  localparam int ST_SHIFT = 1;
  localparam int ST_ARK   = 2;

  logic [NS-1:0]    v;
  logic [BLK_W-1:0] s0;
  logic [BLK_W-1:0] s1;
  logic [BLK_W-1:0] s2;
  logic [BLK_W-1:0] k0;
  logic [BLK_W-1:0] k1;

  logic adv2;
  logic en2;
  logic en1;
  logic en0;
  logic accept;

  // ShiftRows on a column-major state: word c, row r sits at bits
  // [127-32c-8r -: 8]; row r of output column c comes from input column (c+r) mod 4.
  function automatic logic [BLK_W-1:0] shiftrows(input logic [BLK_W-1:0] st);
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] ws0;
    logic [31:0] ws1;
    logic [31:0] ws2;
    logic [31:0] ws3;
    w0  = st[127:96];
    w1  = st[95:64];
    w2  = st[63:32];
    w3  = st[31:0];
    ws0 = {w0[31:24], w1[23:16], w2[15:8], w3[7:0]};
    ws1 = {w1[31:24], w2[23:16], w3[15:8], w0[7:0]};
    ws2 = {w2[31:24], w3[23:16], w0[15:8], w1[7:0]};
    ws3 = {w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    return {ws0, ws1, ws2, ws3};
  endfunction

  // Advance chain: each stage may load when it is empty or when the stage
  // after it is moving, so a full pipe with a ready consumer stays bubble-free.
  always_comb begin
    adv2   = v[ST_ARK] & bus.out_ready;
    en2    = !v[ST_ARK] | adv2;
    en1    = !v[ST_SHIFT] | (v[ST_SHIFT] & en2);
    en0    = !v[ST_SUB] | (v[ST_SUB] & en1);
    accept = bus.in_valid & en0;
  end

  // The external S-box substitutes the incoming block combinationally.
  assign bus.old_sbox  = bus.in_block;
  assign bus.in_ready  = en0;
  assign bus.out_valid = v[ST_ARK];
  assign bus.out_block = s2;
  assign bus.busy      = |v;

  // Stage 0: capture substituted bytes and the key that belongs to this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v[ST_SUB] <= 1'b0;
      s0        <= '0;
      k0        <= '0;
    end else if (accept) begin
      v[ST_SUB] <= 1'b1;
      s0        <= bus.new_sbox;
      k0        <= bus.round_key;
    end else if (en0) begin
      v[ST_SUB] <= 1'b0;
    end
  end

  // Stage 1: ShiftRows; the key travels alongside its block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v[ST_SHIFT] <= 1'b0;
      s1          <= '0;
      k1          <= '0;
    end else if (en1) begin
      v[ST_SHIFT] <= v[ST_SUB];
      s1          <= shiftrows(s0);
      k1          <= k0;
    end
  end

  // Stage 2: AddRoundKey; holds while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v[ST_ARK] <= 1'b0;
      s2        <= '0;
    end else if (en2) begin
      v[ST_ARK] <= v[ST_SHIFT];
      s2        <= s1 ^ k1;
    end
  end
endmodule

// File: tb/tb_aes_encipher_last_block.sv
// tb/tb_aes_encipher_last_block.sv - randomized self-checking bench for the last AES encipher round
module tb_aes_encipher_last_block;
  logic clk;
  logic reset;

  aes_encipher_last_block_if bus ();

  aes_encipher_last_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks;
  int n_errors;
  logic [127:0] exp_q[$];
  logic         prev_stall;
  logic [127:0] prev_block;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply, AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] e;
    inv  = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
      e    = {1'b0, e[7:1]};
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Whole-round reference on a 4x4 byte matrix: st[row][col]
  function automatic logic [127:0] ref_cipher(input logic [127:0] blk, input logic [127:0] key);
    logic [7:0]   st [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = sbox(blk[127 - 32*c - 8*r -: 8]);
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 32*c - 8*r -: 8] = st[r][(c + r) % 4];
    return res ^ key;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // external S-box array model
  always_comb begin
    bus.new_sbox = '0;
    for (int i = 0; i < 16; i++)
      bus.new_sbox[8*i +: 8] = sbox(bus.old_sbox[8*i +: 8]);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      tick();
      g++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard: handshakes seen at the negedge complete on the next posedge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", bus.out_block, prev_block);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_output", 128'd1, 128'd0);
        else check("out_block", bus.out_block, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_cipher(bus.in_block, bus.round_key));
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_block <= bus.out_block;
    end
  end

  initial begin
    logic [127:0] key_a;
    logic [127:0] blk_x;
    logic         acc;
    int           accepted;
    int           stall;
    int           guard;

    n_checks      = 0;
    n_errors      = 0;
    prev_stall    = 1'b0;
    prev_block    = '0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.round_key = '0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_out_block", bus.out_block, 128'd0);
    tick();
    reset = 1'b0;
    tick();

    // FIPS-197 last-round vector with latency check
    bus.in_block  = 128'heb40f21e592e38848ba113e71bc342d2;
    bus.round_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("lat_edge0", 128'(bus.out_valid), 128'd0);
    tick();
    check("lat_edge1", 128'(bus.out_valid), 128'd0);
    tick();
    check("lat_edge2", 128'(bus.out_valid), 128'd1);
    check("fips_vector", bus.out_block, 128'h3925841d02dc09fbdc118597196a0b32);
    drain();

    // zero block with zero and all-ones keys, back to back
    bus.in_block  = '0;
    bus.round_key = '0;
    bus.in_valid  = 1'b1;
    tick();
    bus.round_key = '1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("b2b_first_valid", 128'(bus.out_valid), 128'd1);
    check("zero_key0", bus.out_block, {16{8'h63}});
    tick();
    check("b2b_second_valid", 128'(bus.out_valid), 128'd1);
    check("zero_keyff", bus.out_block, {16{8'h9c}});
    drain();

    // 8 random blocks, consumer stalled for 5 cycles from the start
    bus.out_ready = 1'b0;
    accepted      = 0;
    stall         = 0;
    guard         = 0;
    bus.in_valid  = 1'b1;
    bus.in_block  = rand128();
    bus.round_key = rand128();
    while (accepted < 8 && guard < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      guard++;
      if (acc) begin
        accepted++;
        bus.in_block  = rand128();
        bus.round_key = rand128();
      end
      if (!bus.out_ready) begin
        stall++;
        if (stall == 5) begin
          check("fill_count", 128'(accepted), 128'd3);
          check("in_ready_full", 128'(bus.in_ready), 128'd0);
          bus.out_ready = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
    check("stream_accepted", 128'(accepted), 128'd8);
    drain();

    // key changes the cycle after acceptance
    key_a         = rand128();
    blk_x         = rand128();
    bus.in_block  = blk_x;
    bus.round_key = key_a;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.round_key = ~key_a;
    bus.in_block  = rand128();
    tick();
    tick();
    check("key_held_valid", 128'(bus.out_valid), 128'd1);
    check("key_held", bus.out_block, ref_cipher(blk_x, key_a));
    drain();

    // reset with two blocks in flight
    bus.in_block = rand128();
    bus.in_valid = 1'b1;
    tick();
    bus.in_block = rand128();
    tick();
    bus.in_valid = 1'b0;
    check("flight_busy", 128'(bus.busy), 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("mid_rst_busy", 128'(bus.busy), 128'd0);
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale_output", 128'(bus.out_valid), 128'd0);
    end

    // full pipe, continuous flow for 20 cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_block  = rand128();
      bus.round_key = rand128();
      tick();
    end
    bus.in_block  = rand128();
    bus.round_key = rand128();
    check("full_in_ready", 128'(bus.in_ready), 128'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("flow_in_ready", 128'(bus.in_ready), 128'd1);
      check("flow_out_valid", 128'(bus.out_valid), 128'd1);
      tick();
      bus.in_block  = rand128();
      bus.round_key = rand128();
    end
    bus.in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
